// File: rtl/mpu_pkg.sv
// Shared constants, opcodes and helpers for the MPU operand path.
// Matrices are flattened row-major, 8 bits per element, MSB of each element at its lowest index.
package mpu_pkg;

    localparam int unsigned MATRIX_DIM    = 5;
    localparam int unsigned ELEMENT_WIDTH = 8;
    localparam int unsigned MATRIX_BITS   = ELEMENT_WIDTH * MATRIX_DIM * MATRIX_DIM;

    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_SUB   = 3'd1;
    localparam logic [2:0] OP_IMUL  = 3'd2;
    localparam logic [2:0] OP_OPP   = 3'd3;
    localparam logic [2:0] OP_TRANS = 3'd4;
    localparam logic [2:0] OP_DET   = 3'd5;
    localparam logic [2:0] OP_MUL   = 3'd6;
    localparam logic [2:0] OP_RSVD  = 3'd7;

    typedef enum logic [1:0] {
        StIdle,
        StLoadA,
        StLoadB,
        StHold
    } load_state_e;

    function automatic logic needs_matrix_b(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL);
    endfunction

    // Lowest declared bit index of element (r,c); the element occupies this index and the next 7.
    function automatic int unsigned element_lsb_index(input logic [2:0] r, input logic [2:0] c);
        return ELEMENT_WIDTH * (MATRIX_DIM * {29'd0, r} + {29'd0, c});
    endfunction

endpackage

// File: rtl/mpu_operand_loader_if.sv
// Command, element-stream and operand-set handshakes of the operand loader.
interface mpu_operand_loader_if;
    import mpu_pkg::*;

    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [2:0]             cmd_operation;
    logic [7:0]             cmd_size;
    logic [7:0]             cmd_factor;
    logic                   in_valid;
    logic                   in_ready;
    logic [7:0]             in_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [2:0]             operation;
    logic [0:MATRIX_BITS-1] matrix_a;
    logic [0:MATRIX_BITS-1] matrix_b;
    logic [7:0]             size;
    logic [7:0]             factor;
    logic                   error;

    modport master (
        output cmd_valid, cmd_operation, cmd_size, cmd_factor, in_valid, in_data, out_ready,
        input  cmd_ready, in_ready, out_valid, operation, matrix_a, matrix_b, size, factor, error
    );

    modport slave (
        input  cmd_valid, cmd_operation, cmd_size, cmd_factor, in_valid, in_data, out_ready,
        output cmd_ready, in_ready, out_valid, operation, matrix_a, matrix_b, size, factor, error
    );

endinterface

// File: rtl/mpu_element_counter.sv
// Row/column position counter for an N x N row-major element stream.
module mpu_element_counter (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       clear,
    input  logic       advance,
    input  logic [7:0] size,
    output logic [2:0] row,
    output logic [2:0] col,
    output logic       last
);

    logic [2:0] row_q, row_d;
    logic [2:0] col_q, col_d;
    logic       col_wrap;

    assign col_wrap = ({5'd0, col_q} == size - 8'd1);
    assign last     = col_wrap && ({5'd0, row_q} == size - 8'd1);
    assign row      = row_q;
    assign col      = col_q;

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clear) begin
            row_d = 3'd0;
            col_d = 3'd0;
        end else if (advance) begin
            if (col_wrap) begin
                col_d = 3'd0;
                row_d = row_q + 3'd1;
            end else begin
                col_d = col_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            row_q <= 3'd0;
            col_q <= 3'd0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

endmodule

// File: rtl/mpu_operand_loader.sv
// Collects a command and its row-major element stream into zero-padded 5x5 operand matrices
// and holds the complete operand set until downstream takes it.
module mpu_operand_loader #(
    parameter int unsigned MATRIX_DIM    = mpu_pkg::MATRIX_DIM,
    parameter int unsigned ELEMENT_WIDTH = mpu_pkg::ELEMENT_WIDTH
) (
    input logic                 clock,
    input logic                 reset_n,
    mpu_operand_loader_if.slave bus
);
    import mpu_pkg::*;

    load_state_e            state_q, state_d;
    logic                   cmd_ready_q, cmd_ready_d;
    logic                   in_ready_q, in_ready_d;
    logic                   out_valid_q, out_valid_d;
    logic                   error_q, error_d;
    logic [2:0]             op_q;
    logic [7:0]             size_q;
    logic [7:0]             factor_q;
    logic [0:MATRIX_BITS-1] mat_a_q;
    logic [0:MATRIX_BITS-1] mat_b_q;

    logic       cmd_fire, cmd_ok, cmd_accept, elem_fire, last;
    logic [2:0] row, col;

    assign cmd_fire   = bus.cmd_valid && cmd_ready_q;
    assign cmd_ok     = (bus.cmd_size != 8'd0) && (bus.cmd_size <= 8'(MATRIX_DIM)) &&
                        (bus.cmd_operation != OP_DET) && (bus.cmd_operation != OP_RSVD);
    assign cmd_accept = cmd_fire && cmd_ok;
    assign elem_fire  = bus.in_valid && in_ready_q;

    // One counter serves both matrices; it restarts on every command and after each matrix.
    mpu_element_counter u_counter (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (cmd_accept || (elem_fire && last)),
        .advance (elem_fire),
        .size    (size_q),
        .row     (row),
        .col     (col),
        .last    (last)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (cmd_accept) state_d = StLoadA;
            StLoadA: if (elem_fire && last) state_d = needs_matrix_b(op_q) ? StLoadB : StHold;
            StLoadB: if (elem_fire && last) state_d = StHold;
            StHold:  if (out_valid_q && bus.out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
        // Handshake outputs are registered copies of the next state.
        cmd_ready_d = (state_d == StIdle);
        in_ready_d  = (state_d == StLoadA) || (state_d == StLoadB);
        out_valid_d = (state_d == StHold);
        error_d     = cmd_fire && !cmd_ok;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            cmd_ready_q <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            error_q     <= 1'b0;
            op_q        <= 3'd0;
            size_q      <= 8'd0;
            factor_q    <= 8'd0;
            mat_a_q     <= '0;
            mat_b_q     <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            error_q     <= error_d;
            if (cmd_accept) begin
                op_q     <= bus.cmd_operation;
                size_q   <= bus.cmd_size;
                factor_q <= bus.cmd_factor;
                mat_a_q  <= '0;
                mat_b_q  <= '0;
            end else if (elem_fire) begin
                if (state_q == StLoadA) begin
                    mat_a_q[element_lsb_index(row, col) +: ELEMENT_WIDTH] <= bus.in_data;
                end else begin
                    mat_b_q[element_lsb_index(row, col) +: ELEMENT_WIDTH] <= bus.in_data;
                end
            end
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.error     = error_q;
    assign bus.operation = op_q;
    assign bus.size      = size_q;
    assign bus.factor    = factor_q;
    assign bus.matrix_a  = mat_a_q;
    assign bus.matrix_b  = mat_b_q;

endmodule

// File: tb/tb_mpu_operand_loader.sv
// Directed bench for mpu_operand_loader with a transaction-level reference model.
module tb_mpu_operand_loader;

    logic clk = 1'b0;
    logic reset_n;

    mpu_operand_loader_if ifc ();

    mpu_operand_loader dut (
        .clock   (clk),
        .reset_n (reset_n),
        .bus     (ifc.slave)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model state: phase 0 idle, 1 collecting elements, 2 holding the operand set
    int         phase   = 0;
    bit         exp_rst = 1'b1;
    bit         exp_err = 1'b0;
    logic [2:0] exp_op  = 3'd0;
    logic [7:0] exp_sz  = 8'd0;
    logic [7:0] exp_fac = 8'd0;
    int         exp_a[25];
    int         exp_b[25];
    int         cnt     = 0;
    int         total   = 0;
    int         cyc     = 0;
    int         cmd_edge = 0;
    int         ov_edge  = 0;
    bit         ov_prev  = 1'b0;

    task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [0:199] pack(input int m[25]);
        logic [0:199] v;
        logic [7:0]   e;
        v = '0;
        for (int k = 0; k < 25; k++) begin
            e = m[k][7:0];
            v[8*k +: 8] = e;
        end
        return v;
    endfunction

    function automatic bit legal(input logic [2:0] op, input logic [7:0] sz);
        return (sz >= 8'd1) && (sz <= 8'd5) && (op != 3'd5) && (op != 3'd7);
    endfunction

    always @(posedge clk) begin
        int n;
        cyc     <= cyc + 1;
        exp_err <= 1'b0;
        if (!reset_n) begin
            phase   <= 0;
            exp_rst <= 1'b1;
            exp_op  <= 3'd0;
            exp_sz  <= 8'd0;
            exp_fac <= 8'd0;
            cnt     <= 0;
            for (int k = 0; k < 25; k++) begin
                exp_a[k] <= 0;
                exp_b[k] <= 0;
            end
        end else begin
            exp_rst <= 1'b0;
            n = int'(exp_sz);
            if (phase == 0 && !exp_rst && ifc.cmd_valid) begin
                if (legal(ifc.cmd_operation, ifc.cmd_size)) begin
                    exp_op   <= ifc.cmd_operation;
                    exp_sz   <= ifc.cmd_size;
                    exp_fac  <= ifc.cmd_factor;
                    cnt      <= 0;
                    total    <= int'(ifc.cmd_size) * int'(ifc.cmd_size) *
                                ((ifc.cmd_operation inside {3'd0, 3'd1, 3'd6}) ? 2 : 1);
                    phase    <= 1;
                    cmd_edge <= cyc + 1;
                    for (int k = 0; k < 25; k++) begin
                        exp_a[k] <= 0;
                        exp_b[k] <= 0;
                    end
                end else begin
                    exp_err <= 1'b1;
                end
            end else if (phase == 1 && ifc.in_valid) begin
                if (cnt < n * n) exp_a[(cnt / n) * 5 + cnt % n] <= int'(ifc.in_data);
                else exp_b[((cnt - n * n) / n) * 5 + (cnt - n * n) % n] <= int'(ifc.in_data);
                cnt <= cnt + 1;
                if (cnt + 1 == total) phase <= 2;
            end else if (phase == 2 && ifc.out_ready) begin
                phase <= 0;
            end
        end
    end

    // Every output is compared against the model each cycle, away from the clock edge
    always @(posedge clk) begin
        #2;
        chk("cmd_ready", ifc.cmd_ready, (phase == 0 && !exp_rst));
        chk("in_ready", ifc.in_ready, (phase == 1));
        chk("out_valid", ifc.out_valid, (phase == 2));
        chk("error", ifc.error, exp_err);
        chk("operation", ifc.operation, exp_op);
        chk("size", ifc.size, exp_sz);
        chk("factor", ifc.factor, exp_fac);
        chk("matrix_a", ifc.matrix_a, pack(exp_a));
        chk("matrix_b", ifc.matrix_b, pack(exp_b));
        if (ifc.out_valid && !ov_prev) ov_edge = cyc;
        ov_prev = ifc.out_valid;
    end

    task automatic send_cmd(input logic [2:0] op, input logic [7:0] sz, input logic [7:0] f);
        int w = 0;
        while (!ifc.cmd_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("cmd_wait", ifc.cmd_ready, 1);
        ifc.cmd_valid     = 1'b1;
        ifc.cmd_operation = op;
        ifc.cmd_size      = sz;
        ifc.cmd_factor    = f;
        @(negedge clk);
        ifc.cmd_valid = 1'b0;
    endtask

    task automatic send_elems(input int vals[$], input bit gaps);
        int w;
        foreach (vals[i]) begin
            if (gaps) begin
                ifc.in_valid = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            ifc.in_valid = 1'b1;
            ifc.in_data  = vals[i][7:0];
            w = 0;
            while (!ifc.in_ready && w < 100) begin
                @(negedge clk);
                w++;
            end
            chk("in_wait", ifc.in_ready, 1);
            @(negedge clk);
        end
        ifc.in_valid = 1'b0;
    endtask

    task automatic release_hold;
        int w = 0;
        while (!ifc.out_valid && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("hold_wait", ifc.out_valid, 1);
        ifc.out_ready = 1'b1;
        @(negedge clk);
        ifc.out_ready = 1'b0;
        chk("cmd_ready_after_hold", ifc.cmd_ready, 1);
        chk("out_valid_after_hold", ifc.out_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int q[$];
        ifc.cmd_valid     = 1'b0;
        ifc.cmd_operation = 3'd0;
        ifc.cmd_size      = 8'd0;
        ifc.cmd_factor    = 8'd0;
        ifc.in_valid      = 1'b0;
        ifc.in_data       = 8'd0;
        ifc.out_ready     = 1'b0;
        reset_n           = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_cmd_ready", ifc.cmd_ready, 0);
        chk("reset_matrix_a", ifc.matrix_a, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // add, N=2
        send_cmd(3'd0, 8'd2, 8'd0);
        q = '{1, 2, 3, 4, 5, 6, 7, 8};
        send_elems(q, 1'b0);
        chk("t1_out_valid", ifc.out_valid, 1);
        chk("t1_latency", ov_edge - cmd_edge, 8);
        chk("t1_a00", ifc.matrix_a[0 +: 8], 8'd1);
        chk("t1_a01", ifc.matrix_a[8 +: 8], 8'd2);
        chk("t1_a10", ifc.matrix_a[40 +: 8], 8'd3);
        chk("t1_a11", ifc.matrix_a[48 +: 8], 8'd4);
        chk("t1_a02", ifc.matrix_a[16 +: 8], 8'd0);
        chk("t1_b11", ifc.matrix_b[48 +: 8], 8'd8);
        release_hold();

        // opposite, N=5, A only
        send_cmd(3'd3, 8'd5, 8'd0);
        q.delete();
        for (int i = 1; i <= 25; i++) q.push_back(-i);
        send_elems(q, 1'b0);
        chk("t2_in_ready_drop", ifc.in_ready, 0);
        chk("t2_out_valid", ifc.out_valid, 1);
        chk("t2_a44", ifc.matrix_a[192 +: 8], 8'hE7);
        chk("t2_matrix_b", ifc.matrix_b, 0);
        release_hold();

        // illegal commands: lone one, then back-to-back pair
        send_cmd(3'd0, 8'd0, 8'd0);
        chk("t3_err_size0", ifc.error, 1);
        chk("t3_in_ready", ifc.in_ready, 0);
        chk("t3_cmd_ready", ifc.cmd_ready, 1);
        @(negedge clk);
        chk("t3_err_clear", ifc.error, 0);
        send_cmd(3'd0, 8'd6, 8'd0);
        chk("t3_err_size6", ifc.error, 1);
        send_cmd(3'd5, 8'd2, 8'd0);
        chk("t3_err_op5", ifc.error, 1);
        @(negedge clk);

        // matrix mul, N=3, gaps, held output
        send_cmd(3'd6, 8'd3, 8'd0);
        q = '{10, -20, 30, 40, 50, 60, 70, 80, 90, 1, 2, 3, 4, 5, 6, 7, 8, 9};
        send_elems(q, 1'b1);
        chk("t4_a01", ifc.matrix_a[8 +: 8], 8'hEC);
        chk("t4_b22", ifc.matrix_b[96 +: 8], 8'd9);
        repeat (10) @(negedge clk);
        chk("t4_held", ifc.out_valid, 1);
        release_hold();

        // reset in the middle of loading A
        send_cmd(3'd4, 8'd3, 8'd0);
        q = '{1, 2, 3, 4, 5, 6, 7};
        send_elems(q, 1'b0);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk("t5_rst_matrix_a", ifc.matrix_a, 0);
        chk("t5_rst_in_ready", ifc.in_ready, 0);
        chk("t5_rst_operation", ifc.operation, 0);
        @(negedge clk);
        send_cmd(3'd4, 8'd3, 8'd0);
        q = '{11, 12, 13, 14, 15, 16, 17, 18, 19};
        send_elems(q, 1'b0);
        chk("t5_a00", ifc.matrix_a[0 +: 8], 8'd11);
        chk("t5_a22", ifc.matrix_a[96 +: 8], 8'd19);
        release_hold();

        // int-mul, N=1
        send_cmd(3'd2, 8'd1, 8'hFD);
        q = '{127};
        send_elems(q, 1'b0);
        chk("t6_latency", ov_edge - cmd_edge, 1);
        chk("t6_factor", ifc.factor, 8'hFD);
        chk("t6_a00", ifc.matrix_a[0 +: 8], 8'd127);
        release_hold();

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
